damage_calc: RTL and testbench

DAMAGE_CALC -- requirements
Module: damage_calc

---
 rtl/damage_calc_pkg.sv | 19 +
 rtl/damage_calc_unit.sv | 28 ++
 rtl/damage_calc.sv | 133 +++++++++++++
 tb/tb_damage_calc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/damage_calc_pkg.sv
// Shared definitions for the lane damage calculator.
// Holds the FSM state encoding, the default LANES/DW/TW sizes and the
// minimum "chip" damage applied when an attack does not beat the defense.
package damage_calc_pkg;

  localparam int LANES_DEF  = 8;
  localparam int DW_DEF     = 8;
  localparam int TW_DEF     = 16;
  localparam int MIN_DAMAGE = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/damage_calc_unit.sv
// Combinational damage rule for one attack direction.
// Ports:
//   atk, def           attacker attack / defender defense (DW bits)
//   atkValid, defValid living front unit present on each side
//   dmg                resulting damage (DW bits)
// An attack of zero or a missing unit on either side deals nothing;
// otherwise the defender takes atk-def, but never less than MIN_DAMAGE.
module damage_unit
  import damage_calc_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] atk,
  input  logic [DW-1:0] def,
  input  logic          atkValid,
  input  logic          defValid,
  output logic [DW-1:0] dmg
);

  always_comb begin
    dmg = '0;
    if (atkValid && defValid && (atk != '0)) begin
      if (atk > def) dmg = atk - def;
      else           dmg = DW'(MIN_DAMAGE);
    end
  end

endmodule

// File: rtl/damage_calc.sv
// Lane-by-lane battle damage calculator.
// On start, scans every lane in ascending order: READ requests the lane
// entry, CALC registers both damage values, WRITE emits them and folds them
// into saturating per-side totals. DONE holds the totals until ack.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start, ack                  pass request / release of DONE
//   busy, done                  status (busy outside IDLE, done in DONE)
//   rdEn, rdAddr                lane-table read request and lane index
//   pAtk, pDef, eAtk, eDef      lane unit stats, valid one cycle after rdEn
//   pValid, eValid              lane has a living player / enemy unit
//   wrEn, wrAddr                per-lane result strobe and lane index
//   dmgToEnemy, dmgToPlayer     per-lane damage, qualified by wrEn
//   totToEnemy, totToPlayer     accumulated pass totals
module damage_calc
  import damage_calc_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int TW    = TW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     ack,
  output logic                     busy,
  output logic                     done,
  output logic                     rdEn,
  output logic [$clog2(LANES)-1:0] rdAddr,
  input  logic [DW-1:0]            pAtk,
  input  logic [DW-1:0]            pDef,
  input  logic [DW-1:0]            eAtk,
  input  logic [DW-1:0]            eDef,
  input  logic                     pValid,
  input  logic                     eValid,
  output logic                     wrEn,
  output logic [$clog2(LANES)-1:0] wrAddr,
  output logic [DW-1:0]            dmgToEnemy,
  output logic [DW-1:0]            dmgToPlayer,
  output logic [TW-1:0]            totToEnemy,
  output logic [TW-1:0]            totToPlayer
);

  localparam int AW = $clog2(LANES);
  localparam logic [AW-1:0] LAST_LANE = AW'(LANES - 1);

  state_t          state, nextState;
  logic [AW-1:0]   lane;
  logic [DW-1:0]   dmgEnemy_p0, dmgPlayer_p0;
  logic [DW-1:0]   dmgEnemy_p1, dmgPlayer_p1;

  // Totals clamp at all-ones instead of wrapping.
  function automatic logic [TW-1:0] satAdd(input logic [TW-1:0] tot,
                                           input logic [DW-1:0] d);
    logic [TW:0] sum;
    sum = {1'b0, tot} + {{(TW + 1 - DW){1'b0}}, d};
    return sum[TW] ? {TW{1'b1}} : sum[TW-1:0];
  endfunction

  damage_unit #(.DW(DW)) toEnemyUnit (
    .atk      (pAtk),
    .def      (eDef),
    .atkValid (pValid),
    .defValid (eValid),
    .dmg      (dmgEnemy_p0)
  );

  damage_unit #(.DW(DW)) toPlayerUnit (
    .atk      (eAtk),
    .def      (pDef),
    .atkValid (eValid),
    .defValid (pValid),
    .dmg      (dmgPlayer_p0)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = READ;
      READ:    nextState = CALC;
      CALC:    nextState = WRITE;
      WRITE:   nextState = (lane == LAST_LANE) ? DONE : READ;
      DONE:    if (ack) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    rdEn        = (state == READ);
    wrEn        = (state == WRITE);
    rdAddr      = rdEn ? lane : '0;
    wrAddr      = wrEn ? lane : '0;
    dmgToEnemy  = dmgEnemy_p1;
    dmgToPlayer = dmgPlayer_p1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lane         <= '0;
      dmgEnemy_p1  <= '0;
      dmgPlayer_p1 <= '0;
      totToEnemy   <= '0;
      totToPlayer  <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            lane        <= '0;
            totToEnemy  <= '0;
            totToPlayer <= '0;
          end
        end
        // p0 -> p1: lane data arrives during CALC and is captured here
        CALC: begin
          dmgEnemy_p1  <= dmgEnemy_p0;
          dmgPlayer_p1 <= dmgPlayer_p0;
        end
        // p1 -> totals: fold the written damages into the pass totals
        WRITE: begin
          totToEnemy  <= satAdd(totToEnemy, dmgEnemy_p1);
          totToPlayer <= satAdd(totToPlayer, dmgPlayer_p1);
          if (lane != LAST_LANE) lane <= lane + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_damage_calc.sv
// Self-checking bench for damage_calc: a lane-table model answers reads,
// expected per-lane writes are queued when a pass starts and popped as the
// DUT writes them. A second instance with TW=8 covers total saturation.
module tb_damage_calc;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int TW    = 16;
  localparam int AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0, ack = 1'b0;
  logic          busy, done, rdEn, wrEn;
  logic [AW-1:0] rdAddr, wrAddr;
  logic [DW-1:0] pAtk = '0, pDef = '0, eAtk = '0, eDef = '0;
  logic          pValid = 1'b0, eValid = 1'b0;
  logic [DW-1:0] dmgToEnemy, dmgToPlayer;
  logic [TW-1:0] totToEnemy, totToPlayer;

  logic          start8 = 1'b0, ack8 = 1'b0;
  logic          busy8, done8, rdEn8, wrEn8;
  logic [AW-1:0] rdAddr8, wrAddr8;
  logic [DW-1:0] pAtk8 = '0, pDef8 = '0, eAtk8 = '0, eDef8 = '0;
  logic          pValid8 = 1'b0, eValid8 = 1'b0;
  logic [DW-1:0] dmgToEnemy8, dmgToPlayer8;
  logic [7:0]    totToEnemy8, totToPlayer8;

  logic [DW-1:0] tPAtk [LANES];
  logic [DW-1:0] tPDef [LANES];
  logic [DW-1:0] tEAtk [LANES];
  logic [DW-1:0] tEDef [LANES];
  logic          tPV   [LANES];
  logic          tEV   [LANES];

  damage_calc #(.LANES(LANES), .DW(DW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .busy(busy), .done(done), .rdEn(rdEn), .rdAddr(rdAddr),
    .pAtk(pAtk), .pDef(pDef), .eAtk(eAtk), .eDef(eDef),
    .pValid(pValid), .eValid(eValid),
    .wrEn(wrEn), .wrAddr(wrAddr),
    .dmgToEnemy(dmgToEnemy), .dmgToPlayer(dmgToPlayer),
    .totToEnemy(totToEnemy), .totToPlayer(totToPlayer)
  );

  damage_calc #(.LANES(LANES), .DW(DW), .TW(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ack(ack8),
    .busy(busy8), .done(done8), .rdEn(rdEn8), .rdAddr(rdAddr8),
    .pAtk(pAtk8), .pDef(pDef8), .eAtk(eAtk8), .eDef(eDef8),
    .pValid(pValid8), .eValid(eValid8),
    .wrEn(wrEn8), .wrAddr(wrAddr8),
    .dmgToEnemy(dmgToEnemy8), .dmgToPlayer(dmgToPlayer8),
    .totToEnemy(totToEnemy8), .totToPlayer(totToPlayer8)
  );

  // Lane table: data appears the cycle after the read request.
  always @(posedge clk) begin
    if (rdEn) begin
      pAtk <= tPAtk[rdAddr]; pDef <= tPDef[rdAddr];
      eAtk <= tEAtk[rdAddr]; eDef <= tEDef[rdAddr];
      pValid <= tPV[rdAddr]; eValid <= tEV[rdAddr];
    end
    if (rdEn8) begin
      pAtk8 <= tPAtk[rdAddr8]; pDef8 <= tPDef[rdAddr8];
      eAtk8 <= tEAtk[rdAddr8]; eDef8 <= tEDef[rdAddr8];
      pValid8 <= tPV[rdAddr8]; eValid8 <= tEV[rdAddr8];
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] dE;
    logic [DW-1:0] dP;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [DW-1:0] refDmg(input logic [DW-1:0] atk,
                                           input logic [DW-1:0] def,
                                           input logic av, input logic dv);
    if (!(av && dv) || atk == 0) return '0;
    if (atk > def) return atk - def;
    return 8'd1;
  endfunction

  task automatic setLanes(input logic [DW-1:0] pa, input logic [DW-1:0] pd,
                          input logic [DW-1:0] ea, input logic [DW-1:0] ed,
                          input logic pv, input logic ev);
    for (int i = 0; i < LANES; i++) begin
      tPAtk[i] = pa; tPDef[i] = pd; tEAtk[i] = ea; tEDef[i] = ed;
      tPV[i] = pv; tEV[i] = ev;
    end
  endtask

  task automatic pushPass();
    exp_t e;
    for (int i = 0; i < LANES; i++) begin
      e.addr = AW'(i);
      e.dE   = refDmg(tPAtk[i], tEDef[i], tPV[i], tEV[i]);
      e.dP   = refDmg(tEAtk[i], tPDef[i], tEV[i], tPV[i]);
      sbq.push_back(e);
    end
  endtask

  // One negedge sample: read order, read/write exclusion, write scoreboard.
  task automatic sampleCycle(inout int expRd);
    exp_t e;
    checks++;
    if (rdEn && wrEn) begin
      errors++;
      $display("FAIL rd_wr_overlap: rdEn=%0b wrEn=%0b, required not both high", rdEn, wrEn);
    end
    if (rdEn) begin
      checks++;
      if (rdAddr !== AW'(expRd)) begin
        errors++;
        $display("FAIL read_order: rdAddr=%0d, required %0d", rdAddr, expRd);
      end
      expRd++;
    end
    if (wrEn) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL extra_write: wrAddr=%0d with no write expected", wrAddr);
      end else begin
        e = sbq.pop_front();
        if (wrAddr !== e.addr || dmgToEnemy !== e.dE || dmgToPlayer !== e.dP) begin
          errors++;
          $display("FAIL lane_write: addr=%0d dE=%0d dP=%0d, required addr=%0d dE=%0d dP=%0d",
                   wrAddr, dmgToEnemy, dmgToPlayer, e.addr, e.dE, e.dP);
        end
      end
    end
  endtask

  // Runs a pass; doneCyc is the count of cycles after the start-sampling
  // edge, the first cycle following that edge being cycle 1.
  task automatic runPass(input bit midStart, output int doneCyc);
    int cyc;
    int expRd;
    pushPass();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    doneCyc = 0; cyc = 0; expRd = 0;
    while (cyc < 200 && doneCyc == 0) begin
      @(negedge clk);
      cyc++;
      if (midStart) start = (cyc == 5);
      sampleCycle(expRd);
      if (done) doneCyc = cyc;
    end
    start = 1'b0;
    checks++;
    if (doneCyc == 0) begin
      errors++;
      $display("FAIL done_timeout: done never rose within 200 cycles");
    end
    checks++;
    if (sbq.size() != 0 || expRd != LANES) begin
      errors++;
      $display("FAIL lane_coverage: %0d writes missing, %0d reads, required 0 missing and %0d reads",
               sbq.size(), expRd, LANES);
    end
    sbq.delete();
  endtask

  task automatic checkPass(input string name, input int doneCyc,
                           input int expE, input int expP);
    checks++;
    if (doneCyc != 3 * LANES + 1) begin
      errors++;
      $display("FAIL %s_latency: done at cycle %0d, required %0d", name, doneCyc, 3 * LANES + 1);
    end
    checks++;
    if (totToEnemy !== TW'(expE) || totToPlayer !== TW'(expP)) begin
      errors++;
      $display("FAIL %s_totals: %0d/%0d, required %0d/%0d", name, totToEnemy, totToPlayer, expE, expP);
    end
  endtask

  task automatic doAck();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ack_to_idle: busy=%0b done=%0b, required 0/0", busy, done);
    end
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if ({busy, done, rdEn, wrEn} !== 4'b0 || rdAddr !== '0 || wrAddr !== '0 ||
        dmgToEnemy !== '0 || dmgToPlayer !== '0 || totToEnemy !== '0 || totToPlayer !== '0) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b rdEn=%0b wrEn=%0b rdAddr=%0d wrAddr=%0d dmg=%0d/%0d tot=%0d/%0d, required all 0",
               name, busy, done, rdEn, wrEn, rdAddr, wrAddr, dmgToEnemy, dmgToPlayer,
               totToEnemy, totToPlayer);
    end
  endtask

  task automatic test_reset();
    setLanes(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset_state");
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || totToEnemy8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_state8: busy=%0b done=%0b tot=%0d, required 0", busy8, done8, totToEnemy8);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkAllZero("idle_after_reset");
    end
  endtask

  task automatic test_single_lane();
    int dc;
    setLanes(0, 0, 0, 0, 0, 0);
    tPAtk[0] = 8'd10; tEDef[0] = 8'd3; tEAtk[0] = 8'd2; tPDef[0] = 8'd5;
    tPV[0] = 1'b1; tEV[0] = 1'b1;
    runPass(1'b0, dc);
    checkPass("single_lane", dc, 7, 1);
    doAck();
  endtask

  task automatic test_equal_chip();
    int dc;
    setLanes(8'd4, 8'd4, 8'd4, 8'd4, 1'b1, 1'b1);
    runPass(1'b0, dc);
    checkPass("equal_chip", dc, 8, 8);
    doAck();
  endtask

  task automatic test_invalid();
    int dc;
    setLanes(8'd0, 8'd0, 8'd200, 8'd0, 1'b0, 1'b1);
    runPass(1'b0, dc);
    checkPass("invalid", dc, 0, 0);
    doAck();
  endtask

  task automatic test_hold_ack();
    int dc;
    setLanes(8'd4, 8'd4, 8'd4, 8'd4, 1'b1, 1'b1);
    runPass(1'b1, dc);
    checkPass("mid_start", dc, 8, 8);
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || totToEnemy !== 16'd8 || totToPlayer !== 16'd8) begin
        errors++;
        $display("FAIL hold_done: done=%0b tot=%0d/%0d, required 1 and 8/8", done, totToEnemy, totToPlayer);
      end
    end
    doAck();
    checks++;
    if (totToEnemy !== 16'd8 || totToPlayer !== 16'd8) begin
      errors++;
      $display("FAIL totals_after_ack: %0d/%0d, required 8/8", totToEnemy, totToPlayer);
    end
  endtask

  task automatic test_reset_midpass();
    int cyc;
    int expRd;
    int dc;
    setLanes(8'd10, 8'd5, 8'd2, 8'd3, 1'b1, 1'b1);
    pushPass();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; expRd = 0;
    while (cyc < 11) begin
      @(negedge clk);
      cyc++;
      sampleCycle(expRd);
    end
    // cycle 11 is CALC of lane 3; lanes 0..2 have been written
    checks++;
    if (busy !== 1'b1 || rdEn !== 1'b0 || wrEn !== 1'b0 || totToEnemy !== 16'd21 || totToPlayer !== 16'd3) begin
      errors++;
      $display("FAIL pre_reset_state: busy=%0b rdEn=%0b wrEn=%0b tot=%0d/%0d, required 1/0/0 and 21/3",
               busy, rdEn, wrEn, totToEnemy, totToPlayer);
    end
    reset = 1'b1;
    #1 checkAllZero("midpass_reset");
    sbq.delete();
    @(negedge clk); reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkAllZero("quiet_after_reset");
    end
    runPass(1'b0, dc);
    checkPass("restart", dc, 56, 8);
    doAck();
  endtask

  task automatic test_saturate();
    int cyc;
    setLanes(8'd255, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    cyc = 0;
    while (cyc < 200 && done8 !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done8 !== 1'b1) begin
      errors++;
      $display("FAIL sat_timeout: done8 never rose within 200 cycles");
    end
    checks++;
    if (totToEnemy8 !== 8'd255 || totToPlayer8 !== 8'd0) begin
      errors++;
      $display("FAIL saturate: tot=%0d/%0d, required 255/0", totToEnemy8, totToPlayer8);
    end
    @(negedge clk); ack8 = 1'b1;
    @(posedge clk); #1 ack8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_equal_chip();
    test_invalid();
    test_hold_ack();
    test_reset_midpass();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
